// File: rtl/instr_fetch_decode_if.sv
// Program-RAM read bus and decoded-instruction handshake for instr_fetch_decode.
// The master modport is the fetch/decode block; slave is the RAM/consumer side.
interface instr_fetch_decode_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
);
  logic              Start;
  logic              Enable;
  logic              RW;
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] Mem_data;
  logic              Instr_valid;
  logic              Instr_ready;
  logic              Branch_en;
  logic [ADDR_W-1:0] Branch_addr;
  logic [31:0]       Instruction;
  logic [3:0]        Cond;
  logic [3:0]        OpCode;
  logic              S;
  logic [3:0]        destination;
  logic [3:0]        source_2;
  logic [3:0]        source_1;
  logic [4:0]        IV;
  logic [ADDR_W-1:0] pc;
  logic              Done;

  modport master (
    input  Start, Mem_data, Instr_ready, Branch_en, Branch_addr,
    output Enable, RW, Address, Instr_valid, Instruction, Cond, OpCode, S,
           destination, source_2, source_1, IV, pc, Done
  );

  modport slave (
    output Start, Mem_data, Instr_ready, Branch_en, Branch_addr,
    input  Enable, RW, Address, Instr_valid, Instruction, Cond, OpCode, S,
           destination, source_2, source_1, IV, pc, Done
  );
endinterface

// File: rtl/instr_fetch_decode.sv
// Sequential program-RAM reader: fetches BASE_ADDR..LAST_ADDR, splits each word
// into instruction fields and hands it over valid/ready, with optional branch.
module instr_fetch_decode #(
  parameter int unsigned       ADDR_W      = 16,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       RAM_LATENCY = 1,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(0),
  parameter logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(9)
) (
  input  logic                 Clk,
  input  logic                 Reset,
  instr_fetch_decode_if.master bus
);
  localparam int unsigned       INSTR_W  = 32;
  localparam int unsigned       CNT_W    = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(RAM_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_VALID,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                enable_q, enable_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;

  // Next state; cnt counts edges since entering REQ so capture lands on the
  // RAM_LATENCY-th one (REQ exits straight to VALID when the latency is 1).
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    done_d  = done_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.Start) begin
          pc_d    = BASE_ADDR;
          done_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ, S_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          instr_d = INSTR_W'(bus.Mem_data);
          valid_d = 1'b1;
          state_d = S_VALID;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_WAIT;
        end
      end
      S_VALID: begin
        if (bus.Instr_ready) begin
          valid_d = 1'b0;
          // End-of-program test uses the current pc, so wrap cannot cause runaway fetches.
          if ((pc_q >= LAST_ADDR) && !bus.Branch_en) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            pc_d    = bus.Branch_en ? bus.Branch_addr : pc_q + ADDR_W'(1);
            cnt_d   = '0;
            state_d = S_REQ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    enable_d  = (state_d == S_REQ);
    address_d = enable_d ? pc_d : '0;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      pc_q      <= BASE_ADDR;
      address_q <= '0;
      instr_q   <= '0;
      cnt_q     <= '0;
      enable_q  <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      address_q <= address_d;
      instr_q   <= instr_d;
      cnt_q     <= cnt_d;
      enable_q  <= enable_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end

  assign bus.Enable      = enable_q;
  assign bus.RW          = enable_q;
  assign bus.Address     = address_q;
  assign bus.Instr_valid = valid_q;
  assign bus.Done        = done_q;
  assign bus.pc          = pc_q;
  assign bus.Instruction = instr_q;

  // Field map of the held instruction word.
  assign bus.Cond        = instr_q[31:28];
  assign bus.OpCode      = instr_q[27:24];
  assign bus.S           = instr_q[23];
  assign bus.destination = instr_q[22:19];
  assign bus.source_2    = instr_q[18:15];
  assign bus.source_1    = instr_q[14:11];
  assign bus.IV          = instr_q[10:6];
endmodule

// File: tb/tb_instr_fetch_decode.sv
// Bench for instr_fetch_decode: two instances (RAM latency 1 and 3) driven by shared
// stimulus, each checked every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_instr_fetch_decode;
  localparam logic [15:0] BASE = 16'h0000;
  localparam logic [15:0] LAST = 16'h0009;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        ready = 1'b0;
  logic        br_en = 1'b0;
  logic [15:0] br_addr = 16'h0000;
  logic [31:0] ram [0:65535];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LAT = (g == 0) ? 1 : 3;

    instr_fetch_decode_if #(.ADDR_W(16), .DATA_W(32)) ifc ();
    logic [31:0] mem_q = 32'hDEAD_BEEF;

    assign ifc.Start       = start;
    assign ifc.Instr_ready = ready;
    assign ifc.Branch_en   = br_en;
    assign ifc.Branch_addr = br_addr;
    assign ifc.Mem_data    = mem_q;

    instr_fetch_decode #(
      .ADDR_W(16), .DATA_W(32), .RAM_LATENCY(LAT),
      .BASE_ADDR(16'h0000), .LAST_ADDR(16'h0009)
    ) dut (
      .Clk  (clk),
      .Reset(rst),
      .bus  (ifc.master)
    );

    // RAM: word valid only just before the LAT-th edge after the request; noise otherwise.
    int          rem = 0;
    bit          pend = 1'b0;
    logic [15:0] raddr = 16'h0000;
    always @(negedge clk) begin
      if (rst) begin
        rem  = 0;
        pend = 1'b0;
      end else if (ifc.Enable) begin
        raddr = ifc.Address;
        rem   = LAT - 1;
        pend  = 1'b1;
      end else if (rem > 0) begin
        rem--;
      end
      if (pend && rem == 0) begin
        mem_q = ram[raddr];
        pend  = 1'b0;
      end else begin
        mem_q = $urandom();
      end
    end

    // Model: a fetch takes LAT edges after entering the request; idle = nothing held or pending.
    bit          m_en, m_valid, m_done, m_enter;
    logic [15:0] m_pc;
    logic [31:0] m_instr;
    int          m_left;
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        m_en = 1'b0; m_valid = 1'b0; m_done = 1'b0;
        m_pc = BASE; m_instr = 32'h0; m_left = 0;
      end else begin
        m_enter = 1'b0;
        if (!m_valid && m_left == 0) begin
          if (start) begin
            m_pc = BASE; m_done = 1'b0; m_enter = 1'b1;
          end
        end else if (m_left > 0) begin
          m_left--;
          if (m_left == 0) begin
            m_instr = ram[m_pc];
            m_valid = 1'b1;
          end
        end else if (ready) begin
          m_valid = 1'b0;
          if (m_pc >= LAST && !br_en) m_done = 1'b1;
          else begin
            m_pc    = br_en ? br_addr : m_pc + 16'd1;
            m_enter = 1'b1;
          end
        end
        if (m_enter) m_left = LAT;
        m_en = m_enter;
      end
    end

    always @(negedge clk) begin
      if (!rst) begin
        chk($sformatf("lat%0d ctrl{en,rw,addr,valid,done,pc}", LAT),
            {ifc.Enable, ifc.RW, ifc.Address, ifc.Instr_valid, ifc.Done, ifc.pc},
            {m_en, m_en, (m_en ? m_pc : 16'h0), m_valid, m_done, m_pc});
        chk($sformatf("lat%0d Instruction", LAT), ifc.Instruction, m_instr);
        chk($sformatf("lat%0d fields", LAT),
            {ifc.Cond, ifc.OpCode, ifc.S, ifc.destination, ifc.source_2, ifc.source_1, ifc.IV},
            {m_instr[31:28], m_instr[27:24], m_instr[23], m_instr[22:19],
             m_instr[18:15], m_instr[14:11], m_instr[10:6]});
      end
    end
  end

  task automatic wait_all_done(input string name);
    int n = 0;
    while (!(lane[0].ifc.Done && lane[1].ifc.Done) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(name, {63'h0, lane[0].ifc.Done && lane[1].ifc.Done}, 64'h1);
  endtask

  logic [15:0] addrs[$];
  int          n;
  bit          hit, ign_done;

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = $urandom();
    ram[0] = 32'h0628_0060;
    ram[9] = 32'h1618_03F8;

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset ctrl", {lane[0].ifc.Enable, lane[0].ifc.RW, lane[0].ifc.Address,
                       lane[0].ifc.Instr_valid, lane[0].ifc.Done, lane[0].ifc.pc}, 64'h0);
    chk("reset Instruction", lane[0].ifc.Instruction, 64'h0);

    // First fetch: request in cycle 0, data valid from edge 1.
    rst = 1'b0; ready = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("cycle0 {en,rw,addr}", {lane[0].ifc.Enable, lane[0].ifc.RW, lane[0].ifc.Address},
        {1'b1, 1'b1, 16'h0000});
    chk("cycle0 valid", {63'h0, lane[0].ifc.Instr_valid}, 64'h0);
    @(posedge clk); #1;
    chk("edge1 valid", {63'h0, lane[0].ifc.Instr_valid}, 64'h1);
    chk("word0 fields", {lane[0].ifc.Cond, lane[0].ifc.OpCode, lane[0].ifc.S, lane[0].ifc.destination,
                         lane[0].ifc.source_2, lane[0].ifc.source_1, lane[0].ifc.IV},
        {4'h0, 4'h6, 1'b0, 4'h5, 4'h0, 4'h0, 5'd1});

    addrs.delete(); n = 0;
    while (!lane[0].ifc.Done && n < 100) begin
      @(negedge clk); n++;
      if (lane[0].ifc.Instr_valid && ready) begin
        addrs.push_back(lane[0].ifc.pc);
        if (lane[0].ifc.pc == 16'd9)
          chk("word9 fields", {lane[0].ifc.Cond, lane[0].ifc.OpCode, lane[0].ifc.S, lane[0].ifc.destination,
                               lane[0].ifc.source_2, lane[0].ifc.source_1, lane[0].ifc.IV},
              {4'h1, 4'h6, 1'b0, 4'h3, 4'h0, 4'h0, 5'd15});
      end
    end
    chk("handshake count", 64'(addrs.size()), 64'd10);
    for (int i = 0; i < addrs.size() && i < 10; i++) chk("handshake addr", 64'(addrs[i]), 64'(i));
    repeat (4) begin
      @(negedge clk);
      chk("no enable after done", {62'h0, lane[0].ifc.Enable, lane[0].ifc.Done}, 64'h1);
    end
    wait_all_done("run1 done");

    // Stall on pc=3 for five cycles.
    start = 1'b1; @(negedge clk); start = 1'b0;
    n = 0; hit = 1'b0;
    while (!hit && n < 100) begin
      if (lane[0].ifc.Instr_valid && lane[0].ifc.pc == 16'd3) hit = 1'b1;
      else begin @(negedge clk); n++; end
    end
    chk("stall reached", {63'h0, hit}, 64'h1);
    ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("stall {valid,en,pc}", {lane[0].ifc.Instr_valid, lane[0].ifc.Enable, lane[0].ifc.pc},
          {1'b1, 1'b0, 16'd3});
      chk("stall Instruction", lane[0].ifc.Instruction, ram[3]);
    end
    ready = 1'b1;
    @(negedge clk);
    chk("release fetch {en,addr}", {lane[0].ifc.Enable, lane[0].ifc.Address}, {1'b1, 16'd4});
    wait_all_done("run2 done");

    // Ignored branch without handshake at pc=0, taken branch to 7 at pc=2.
    start = 1'b1; @(negedge clk); start = 1'b0;
    addrs.delete(); n = 0; ign_done = 1'b0;
    while (!lane[0].ifc.Done && n < 100) begin
      if (lane[0].ifc.Enable) addrs.push_back(lane[0].ifc.Address);
      br_en = 1'b0; ready = 1'b1;
      if (lane[0].ifc.Instr_valid && lane[0].ifc.pc == 16'd0 && !ign_done) begin
        ready = 1'b0; br_en = 1'b1; br_addr = 16'd5; ign_done = 1'b1;
      end else if (lane[0].ifc.Instr_valid && lane[0].ifc.pc == 16'd2) begin
        br_en = 1'b1; br_addr = 16'd7;
      end
      @(negedge clk); n++;
    end
    br_en = 1'b0; ready = 1'b1;
    chk("branch fetch count", 64'(addrs.size()), 64'd6);
    if (addrs.size() == 6) begin
      chk("branch seq", {addrs[0], addrs[1], addrs[2], addrs[3], addrs[4], addrs[5]},
          {16'd0, 16'd1, 16'd2, 16'd7, 16'd8, 16'd9});
    end
    wait_all_done("run3 done");

    // Random traffic, including branches past LAST_ADDR and to the top address.
    for (int c = 0; c < 3000; c++) begin
      ready   = ($urandom_range(0, 3) != 0);
      br_en   = ($urandom_range(0, 7) == 0);
      br_addr = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom_range(0, 12));
      start   = ($urandom_range(0, 15) == 0);
      @(negedge clk);
    end
    start = 1'b0; br_en = 1'b0; ready = 1'b1;
    wait_all_done("random done");

    // Reset while the latency-3 instance waits on address 5.
    start = 1'b1; @(negedge clk); start = 1'b0;
    n = 0;
    while (!(lane[1].ifc.Enable && lane[1].ifc.Address == 16'd5) && n < 200) begin
      @(negedge clk); n++;
    end
    chk("reached fetch 5", {63'h0, lane[1].ifc.Enable}, 64'h1);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    chk("async reset lat3", {lane[1].ifc.Enable, lane[1].ifc.Instr_valid, lane[1].ifc.Done, lane[1].ifc.pc},
        {1'b0, 1'b0, 1'b0, 16'd0});
    chk("async reset Instruction", lane[1].ifc.Instruction, 64'h0);
    @(negedge clk);
    rst = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("refetch {en,rw,addr}", {lane[1].ifc.Enable, lane[1].ifc.RW, lane[1].ifc.Address},
        {1'b1, 1'b1, 16'd0});
    wait_all_done("final done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
